fft_power_frame: RTL
====================

# fft_power_frame

Power-spectrum stage directly downstream of `stfft`. It consumes the FFT's complex output stream and frame sync, and keeps only the non-redundant bins 0..FFT_SIZE/2 of each real-input frame. For each kept bin it computes |X|² = re² + im² and hands bin-tagged power words to the feature extractor over a valid/ready interface. A small FIFO absorbs consumer stalls, because the FFT cannot be back-pressured.

## Interface
- `IW`, 18: width of each signed FFT output component (re, im).
- `OW`, 36: output power width, 1 ≤ OW ≤ 2*IW. The full power is 2*IW bits unsigned; the top OW bits are emitted (truncation, no rounding).
- `FFT_SIZE`, 256: FFT length, power of two ≥ 8.
- `FIFO_DEPTH`, 16: output FIFO entries, power of two ≥ 4.
- `BW` (localparam) = $clog2(FFT_SIZE/2+1).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `i_ce`, in, 1: FFT output strobe; `i_result` and `i_sync` are valid only when high.
- `i_result`, in, 2*IW: {re, im}, each signed two's complement, natural bin order.
- `i_sync`, in, 1: marks bin 0 of a frame (qualified by `i_ce`).
- `o_valid`, out, 1: FIFO head valid.
- `i_ready`, in, 1: consumer accepts the head.
- `o_power`, out, OW: bin power.
- `o_bin`, out, BW: bin index 0..FFT_SIZE/2.
- `o_last`, out, 1: high when `o_bin` == FFT_SIZE/2.
- `o_overflow`, out, 1: sticky; a kept bin was dropped because the FIFO was full.
- `o_sync_err`, out, 1: one-cycle pulse on a mid-frame `i_sync`.

## Operation
- The FSM has two states.
  - SYNC_WAIT (reset state): all `i_ce` beats without `i_sync` are discarded. A beat with `i_ce & i_sync` is processed as bin 0, sets bin counter `cnt` = 1, and moves to RUN.
  - RUN: each `i_ce` beat is processed as bin `cnt`, then `cnt` increments modulo FFT_SIZE. There is no state change at wrap; the next frame's `i_sync` is expected when `cnt` == 0.
- Resync: `i_ce & i_sync` while in RUN with `cnt` ≠ 0 is processed as bin 0 and sets `cnt` = 1. `o_sync_err` pulses on the next cycle. A partially emitted frame is not repaired, so the consumer sees no `o_last` for that frame.
- `i_sync` absent at `cnt` == 0 is not an error. Counting continues.
- Keep rule: a beat is written into the pipeline only if its bin ≤ FFT_SIZE/2. Bins FFT_SIZE/2+1..FFT_SIZE-1 are dropped silently.
- Arithmetic:
  - Stage 1 registers signed products re*re and im*im, each 2*IW bits.
  - Stage 2 registers the unsigned 2*IW-bit sum. It cannot overflow: max is 2·(2^(IW-1))² = 2^(2IW-1).
  - `o_power` = sum[2*IW-1 -: OW].
- FIFO:
  - Synchronous, FIFO_DEPTH entries of {power, bin}.
  - Write occurs when stage 2 is valid. Read occurs on `o_valid & i_ready`.
  - Write while full with no same-cycle read: the entry is dropped and `o_overflow` is set until reset.
  - Write while full with a same-cycle read: accepted, no overflow.
- Handshake:
  - `o_valid` never deasserts without a transfer.
  - `o_power`, `o_bin` and `o_last` are held stable while `o_valid & !i_ready`.

## Timing
- Reset values: `o_valid`=0, `o_power`=0, `o_bin`=0, `o_last`=0, `o_overflow`=0, `o_sync_err`=0. FIFO empty, FSM in SYNC_WAIT, `cnt`=0, pipeline valid flags cleared.
- Pipeline runs every `clk` with valid tags, independent of `i_ce`. Back-to-back `i_ce` at full clock rate is supported.
- Latency: a beat accepted at cycle t is written to the FIFO at the t+2 edge. If the FIFO was empty, `o_valid` is high in cycle t+3 with that beat's data.
- Throughput: 1 bin per clock in and out.
- Reset mid-operation: reset in any cycle discards pipeline and FIFO contents. Outputs show reset values in the cycle after reset is sampled.
- `o_sync_err` asserts exactly 1 cycle after the offending beat.

## Test plan
- Reset: assert reset for 2 cycles mid-stream. All outputs must be 0 afterwards, and beats before the next `i_sync` must be ignored (no `o_valid`).
- Full frame, `i_ready`=1, FFT_SIZE=256, all bins re=3, im=4: expect 129 outputs with `o_power`=25 and `o_bin`=0..128 consecutive. `o_last` must be high only on bin 128, and first `o_valid` must appear 3 cycles after the sync beat. Bins 129..255 must produce nothing.
- Extremes: re=im=-131072 (IW=18, OW=36) must give `o_power`=34359738368. re=131071, im=0 must give 17179607041. With OW=16, the first case must give 32768.
- Back-pressure: `i_ready`=0 for a whole frame. Exactly 16 entries (bins 0..15) must be held stable, `o_overflow` must set at bin 16 and stay set, and draining must return bins 0..15 in order.
- Full + simultaneous read: FIFO full, toggle `i_ready`=1 exactly on a write cycle. The write must be accepted and `o_overflow` must stay 0.
- Resync: `i_sync` at `cnt`=50. `o_sync_err` must pulse 1 cycle later, and the next outputs must restart at `o_bin`=0 and finish with `o_last` at 128.

Source files
------------

// File: rtl/fft_power_frame.sv
// fft_power_frame: keeps bins 0..FFT_SIZE/2 of each real-input FFT frame and emits bin-tagged |X|^2 words.
// Latency: a beat accepted in cycle t is written to the FIFO at the t+2 edge; o_valid rises in t+3 if the FIFO was empty.
// Backpressure: i_ready stalls only the FIFO head; input never stalls, so a write to a full FIFO is dropped and o_overflow sticks.
// Ports: clk, reset (sync, active-high); i_ce/i_result/i_sync = FFT output beat {re,im} with frame sync;
//        o_valid/i_ready = output handshake carrying o_power, o_bin, o_last; o_overflow = sticky drop flag;
//        o_sync_err = one-cycle pulse on a mid-frame sync.

// Generic synchronous FIFO. A write while full is accepted only if the head is read in the same cycle.
module fft_power_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdat,
  output logic         o_full,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_rd;
  logic         w_wr;

  // Extra pointer MSB distinguishes full from empty.
  assign o_vld  = (r_wptr != r_rptr);
  assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd   = o_vld & i_rdy;
  assign w_wr   = i_wr & (~o_full | w_rd);
  assign o_dat  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // When full with a simultaneous read, the write lands in the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdat;
  end
endmodule

module fft_power_frame #(
  parameter int IW         = 18,
  parameter int OW         = 36,
  parameter int FFT_SIZE   = 256,
  parameter int FIFO_DEPTH = 16,
  localparam int BW        = $clog2(FFT_SIZE/2+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_ce,
  input  logic [2*IW-1:0] i_result,
  input  logic          i_sync,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_power,
  output logic [BW-1:0] o_bin,
  output logic          o_last,
  output logic          o_overflow,
  output logic          o_sync_err
);
  localparam int PW = OW + BW;
  localparam logic [BW-1:0] HALF = BW'(FFT_SIZE/2);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;
  // For power-of-two FFT_SIZE >= 8, BW equals log2(FFT_SIZE), so the counter wraps modulo FFT_SIZE naturally.
  logic [BW-1:0] r_cnt;
  logic [BW-1:0] w_cnt_nxt;
  logic [BW-1:0] w_bin;
  logic          w_take;
  logic          w_serr;
  logic          w_keep;

  logic signed [2*IW-1:0] w_re;
  logic signed [2*IW-1:0] w_im;

  logic                   r_s1_vld;
  logic signed [2*IW-1:0] r_s1_rr;
  logic signed [2*IW-1:0] r_s1_ii;
  logic [BW-1:0]          r_s1_bin;
  logic                   r_s2_vld;
  logic [2*IW-1:0]        r_s2_sum;
  logic [BW-1:0]          r_s2_bin;
  logic                   r_sync_err;
  logic                   r_overflow;

  logic          w_full;
  logic          w_vld;
  logic [PW-1:0] w_head;
  logic          w_unused_sum;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bin       = '0;
    w_take      = 1'b0;
    w_serr      = 1'b0;
    case (r_state)
      SYNC_WAIT: begin
        if (i_ce && i_sync) begin
          w_take      = 1'b1;
          w_cnt_nxt   = BW'(1);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (i_ce) begin
          w_take = 1'b1;
          if (i_sync) begin
            // Sync always restarts the frame; it is only an error away from the expected slot.
            w_cnt_nxt = BW'(1);
            w_serr    = (r_cnt != '0);
          end else begin
            w_bin     = r_cnt;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = SYNC_WAIT;
    endcase
  end

  // Upper half of a real-input spectrum mirrors the lower half.
  assign w_keep = w_take && (w_bin <= HALF);

  assign w_re = {{IW{i_result[2*IW-1]}}, i_result[2*IW-1:IW]};
  assign w_im = {{IW{i_result[IW-1]}}, i_result[IW-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SYNC_WAIT;
      r_cnt      <= '0;
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_sync_err <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s1_vld   <= w_keep;
      r_s2_vld   <= r_s1_vld;
      r_sync_err <= w_serr;
      if (r_s2_vld && w_full && !(w_vld && i_ready)) r_overflow <= 1'b1;
    end
  end

  // Datapath registers carry no reset; the valid tags above qualify them.
  always_ff @(posedge clk) begin
    r_s1_rr  <= w_re * w_re;
    r_s1_ii  <= w_im * w_im;
    r_s1_bin <= w_bin;
    // Each square is at most 2^(2IW-2), so the unsigned sum fits in 2*IW bits.
    r_s2_sum <= r_s1_rr + r_s1_ii;
    r_s2_bin <= r_s1_bin;
  end

  // Low bits below the emitted window are intentionally discarded.
  assign w_unused_sum = ^r_s2_sum;

  fft_power_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_wr   (r_s2_vld),
    .i_wdat ({r_s2_sum[2*IW-1 -: OW], r_s2_bin}),
    .o_full (w_full),
    .o_vld  (w_vld),
    .i_rdy  (i_ready),
    .o_dat  (w_head)
  );

  // Data outputs read zero whenever the FIFO is empty, giving clean reset values without clearing the storage.
  assign o_valid    = w_vld;
  assign o_power    = w_vld ? w_head[PW-1:BW] : '0;
  assign o_bin      = w_vld ? w_head[BW-1:0] : '0;
  assign o_last     = w_vld && (w_head[BW-1:0] == HALF);
  assign o_overflow = r_overflow;
  assign o_sync_err = r_sync_err;
endmodule
